// File: rtl/pixel_ram_stream.sv
`default_nettype none
// =============================================================================
// Module  : pixel_ram_stream
// Brief   : Pixel word buffer for the SK6812RGBW peripheral. Port A is a
//           byte-enabled random-access bus port; port B is a frame streaming
//           engine (valid/ready) that walks words 0..L-1 after a start pulse.
// Options : define PIXRAM_FWD_EN for write-to-read forwarding on both ports.
// Rev     : 1.0  initial release
// =============================================================================
module pixel_ram_stream #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 6,
    parameter int DEPTH    = 35,
    parameter     MEM_FILE = "none"
) (
    input  logic                clk,
    input  logic                rst_n,
    // port A: bus access
    input  logic                a_we,
    input  logic [DATA_W/8-1:0] a_be,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_wdata,
    output logic [DATA_W-1:0]   a_rdata,
    // port B: frame streaming
    input  logic                frame_start,
    input  logic [ADDR_W:0]     frame_len,
    input  logic                abort,
    output logic                s_valid,
    input  logic                s_ready,
    output logic [DATA_W-1:0]   s_data,
    output logic [ADDR_W-1:0]   s_index,
    output logic                s_last,
    output logic                busy,
    output logic                done
);

    localparam int              C_BE_W  = DATA_W / 8;
    localparam int              C_LEN_W = ADDR_W + 1;
    localparam logic [ADDR_W:0] C_DEPTH = C_LEN_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_LOAD  = 2'd2,
        S_VALID = 2'd3
    } state_t;

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_len;

    logic              w_a_in_range;
    logic [DATA_W-1:0] w_a_old;
    logic [DATA_W-1:0] w_a_rd;
    logic [DATA_W-1:0] w_b_old;
    logic [DATA_W-1:0] w_b_rd;
    logic [ADDR_W:0]   w_len_eff;

    assign w_a_in_range = ({1'b0, a_addr} < C_DEPTH);
    assign w_a_old      = w_a_in_range ? r_mem[a_addr] : '0;
    assign w_b_old      = r_mem[r_ptr];
    assign w_len_eff    = (frame_len > C_DEPTH) ? C_DEPTH : frame_len;

`ifdef PIXRAM_FWD_EN
    function automatic logic [DATA_W-1:0] f_merge(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [C_BE_W-1:0] be
    );
        logic [DATA_W-1:0] m;
        m = old_w;
        for (int i = 0; i < C_BE_W; i++) begin
            if (be[i]) m[8*i +: 8] = new_w[8*i +: 8];
        end
        return m;
    endfunction

    assign w_a_rd = (a_we && w_a_in_range) ? f_merge(w_a_old, a_wdata, a_be) : w_a_old;
    // r_ptr is always in range, so a matching write is never dropped
    assign w_b_rd = (a_we && (a_addr == r_ptr)) ? f_merge(w_b_old, a_wdata, a_be) : w_b_old;
`else
    assign w_a_rd = w_a_old;
    assign w_b_rd = w_b_old;
`endif

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (a_we && w_a_in_range) begin
            for (int i = 0; i < C_BE_W; i++) begin
                if (a_be[i]) r_mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rdata <= '0;
        end else begin
            a_rdata <= w_a_rd;
        end
    end

    // FETCH only presents r_ptr to the array; the word is captured leaving LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_len   <= '0;
            s_valid <= 1'b0;
            s_data  <= '0;
            s_index <= '0;
            s_last  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (frame_start) begin
                        if (w_len_eff != '0) begin
                            r_len   <= w_len_eff;
                            r_ptr   <= '0;
                            busy    <= 1'b1;
                            r_state <= S_FETCH;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    if (abort) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        s_data  <= w_b_rd;
                        s_index <= r_ptr;
                        s_last  <= ({1'b0, r_ptr} == (r_len - C_LEN_W'(1)));
                        s_valid <= 1'b1;
                        r_state <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (abort) begin
                        s_valid <= 1'b0;
                        s_last  <= 1'b0;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (s_ready) begin
                        s_valid <= 1'b0;
                        s_last  <= 1'b0;
                        if (s_last) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_ptr   <= r_ptr + ADDR_W'(1);
                            r_state <= S_FETCH;
                        end
                    end
                end
                default: begin
                    s_valid <= 1'b0;
                    s_last  <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pixel_ram_stream.sv
`default_nettype none
// Testbench for pixel_ram_stream: random port A traffic and frame streaming
// checked against a word-array model of the buffer.
module tb_pixel_ram_stream;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 35;
`ifdef PIXRAM_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              a_we = 1'b0;
    logic [3:0]        a_be = 4'h0;
    logic [ADDR_W-1:0] a_addr = '0;
    logic [31:0]       a_wdata = '0;
    logic [31:0]       a_rdata;
    logic              frame_start = 1'b0;
    logic [ADDR_W:0]   frame_len = '0;
    logic              abort = 1'b0;
    logic              s_valid;
    logic              s_ready = 1'b0;
    logic [31:0]       s_data;
    logic [ADDR_W-1:0] s_index;
    logic              s_last;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    pixel_ram_stream #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .MEM_FILE("none")
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_we       (a_we),
        .a_be       (a_be),
        .a_addr     (a_addr),
        .a_wdata    (a_wdata),
        .a_rdata    (a_rdata),
        .frame_start(frame_start),
        .frame_len  (frame_len),
        .abort      (abort),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_index    (s_index),
        .s_last     (s_last),
        .busy       (busy),
        .done       (done)
    );

    logic [31:0] m_mem [DEPTH];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (o & ~mask) | (n & mask);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_rd(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                         input logic [3:0] be, input logic we, input bit do_chk);
        logic [31:0] old;
        logic [31:0] expv;
        bit          inr;
        inr  = (addr < DEPTH);
        old  = inr ? m_mem[addr] : 32'h0;
        expv = (FWD && we && inr) ? merge(old, data, be) : old;
        a_addr = addr; a_wdata = data; a_be = be; a_we = we;
        tick;
        a_we = 1'b0;
        if (do_chk) check("a_rdata", a_rdata, expv);
        if (we && inr) m_mem[addr] = merge(old, data, be);
    endtask

    // Streams one frame. stall_k/abort_k/coll_k = -1 disables that event.
    task automatic run_frame(input int len, input int ready_pct, input int stall_k,
                             input int abort_k, input int coll_k, input bit abort_at_start);
        logic [31:0] exp_q[$];
        logic [31:0] old;
        int L, k, cyc, last_hs, stall_left;
        bit aborted;
        L = (len > DEPTH) ? DEPTH : len;
        for (int i = 0; i < L; i++) exp_q.push_back(m_mem[i]);
        frame_start = 1'b1; frame_len = len[ADDR_W:0]; abort = abort_at_start; s_ready = 1'b0;
        tick;
        frame_start = 1'b0; abort = 1'b0;
        if (L == 0) begin
            check("zero_done", done, 1);
            check("zero_busy", busy, 0);
            tick;
            check("zero_done_clr", done, 0);
            return;
        end
        check("start_busy", busy, 1);
        k = 0; cyc = 0; last_hs = 0; stall_left = 5; aborted = 0;
        while (k < L && !aborted && cyc < 3000) begin
            a_we = 1'b0;
            frame_start = 1'b0;
            s_ready = ($urandom_range(99) < ready_pct);
            if (coll_k >= 0 && cyc == 1 + 3 * coll_k) begin
                old = m_mem[coll_k];
                a_we = 1'b1; a_addr = ADDR_W'(coll_k); a_wdata = 32'hFFFF_FFFF; a_be = 4'hF;
                exp_q[coll_k] = FWD ? 32'hFFFF_FFFF : old;
                m_mem[coll_k] = 32'hFFFF_FFFF;
            end
            if (s_valid) begin
                check("s_data", s_data, exp_q[k]);
                check("s_index", s_index, k);
                check("s_last", s_last, (k == L - 1));
                if (k == stall_k && stall_left > 0) begin
                    s_ready = 1'b0;
                    if (stall_left == 4) begin
                        a_we = 1'b1; a_addr = ADDR_W'(k); a_be = 4'hF; a_wdata = $urandom;
                        m_mem[k] = a_wdata;
                    end
                    if (stall_left == 3) begin
                        frame_start = 1'b1; frame_len = 7'd2;
                    end
                    if (stall_left == 2 && k + 2 < L) begin
                        a_we = 1'b1; a_addr = ADDR_W'(k + 2); a_be = 4'hF; a_wdata = $urandom;
                        m_mem[k + 2] = a_wdata;
                        exp_q[k + 2] = a_wdata;
                    end
                    stall_left--;
                end
                if (abort_k == k) begin
                    abort = 1'b1; s_ready = 1'b1; aborted = 1;
                end else if (s_ready) begin
                    if (ready_pct == 100 && stall_k < 0)
                        check("spacing", cyc - last_hs, (k == 0) ? 2 : 3);
                    last_hs = cyc;
                    k++;
                end
            end
            tick;
            cyc++;
            if (!aborted) check("done", done, (k == L));
        end
        a_we = 1'b0; s_ready = 1'b0; frame_start = 1'b0;
        if (cyc >= 3000) begin
            check("timeout", 1, 0);
        end else if (aborted) begin
            abort = 1'b0;
            check("abort_valid", s_valid, 0);
            check("abort_busy", busy, 0);
            check("abort_last", s_last, 0);
            check("abort_done", done, 0);
            tick;
            check("abort_done2", done, 0);
        end else begin
            check("end_busy", busy, 0);
            check("end_valid", s_valid, 0);
            tick;
            check("done_clr", done, 0);
        end
    endtask

    initial begin
        int wait_cnt;
        repeat (3) tick;
        check("rst_a_rdata", a_rdata, 0);
        check("rst_s_data", s_data, 0);
        check("rst_s_index", s_index, 0);
        check("rst_s_valid", s_valid, 0);
        check("rst_s_last", s_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        tick;

        for (int i = 0; i < DEPTH; i++) wr_rd(ADDR_W'(i), $urandom, 4'hF, 1'b1, 1'b0);

        wr_rd(6'd3, 32'hAABB_CCDD, 4'hF, 1'b1, 1'b1);
        wr_rd(6'd3, 32'h1122_3344, 4'b0101, 1'b1, 1'b1);
        wr_rd(6'd3, 32'h0, 4'h0, 1'b0, 1'b1);
        check("be_merge", a_rdata, 32'hAA22_CC44);

        wr_rd(6'd5, 32'h0, 4'hF, 1'b1, 1'b1);
        wr_rd(6'd5, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1);
        check("coll_a", a_rdata, FWD ? 32'hFFFF_FFFF : 32'h0);
        wr_rd(6'd40, 32'h1234_5678, 4'hF, 1'b1, 1'b1);
        check("oor_read", a_rdata, 0);

        repeat (200) wr_rd(ADDR_W'($urandom_range(63)), $urandom, 4'($urandom_range(15)),
                           1'($urandom_range(1)), 1'b1);

        for (int i = 0; i < 4; i++) wr_rd(ADDR_W'(i), 32'(i + 1), 4'hF, 1'b1, 1'b1);
        run_frame(4, 100, -1, -1, -1, 1'b0);
        run_frame(40, 100, -1, -1, -1, 1'b0);
        run_frame(6, 100, 1, -1, -1, 1'b0);
        run_frame(6, 100, -1, 2, -1, 1'b0);
        run_frame(3, 100, -1, 2, -1, 1'b0);
        run_frame(0, 100, -1, -1, -1, 1'b0);
        run_frame(5, 100, -1, -1, -1, 1'b1);
        wr_rd(6'd5, 32'h0, 4'hF, 1'b1, 1'b1);
        run_frame(8, 100, -1, -1, 5, 1'b0);
        repeat (8) run_frame($urandom_range(40), $urandom_range(30, 100), -1, -1, -1, 1'b0);

        // asynchronous reset in the middle of a frame
        wr_rd(6'd7, 32'h1234_5678, 4'hF, 1'b1, 1'b1);
        frame_start = 1'b1; frame_len = 7'd10; s_ready = 1'b0;
        tick;
        frame_start = 1'b0;
        wait_cnt = 0;
        while (!s_valid && wait_cnt < 10) begin
            tick;
            wait_cnt++;
        end
        check("rst_pre_valid", s_valid, 1);
        check("rst_pre_rdata", a_rdata, 32'h1234_5678);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", s_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_rdata", a_rdata, 0);
        tick;
        rst_n = 1'b1;
        tick;
        check("rst_post_done", done, 0);
        check("rst_post_busy", busy, 0);
        tick;
        check("rst_post_done2", done, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
